// File: rtl/display_modes_pkg.sv
// Video mode table and timing record types for the multi-mode generator.
// Totals and sync edges are derived here so the pixel path only compares.
package display_modes_pkg;

    localparam int FW = 14;
    localparam int NUM_STD_MODES = 9;

    typedef logic [FW-1:0] fld_t;

    typedef struct packed {
        fld_t h_res;
        fld_t h_fp;
        fld_t h_sync;
        fld_t h_bp;
        fld_t v_res;
        fld_t v_fp;
        fld_t v_sync;
        fld_t v_bp;
        logic h_pol;
        logic v_pol;
        fld_t h_tot;
        fld_t v_tot;
        fld_t h_last;
        fld_t v_last;
        fld_t hs_start;
        fld_t hs_end;
        fld_t vs_start;
        fld_t vs_end;
    } mode_t;

    // Subset of a mode that the raster decode actually looks at.
    typedef struct packed {
        fld_t h_res;
        fld_t v_res;
        fld_t h_last;
        fld_t v_last;
        fld_t hs_start;
        fld_t hs_end;
        fld_t vs_start;
        fld_t vs_end;
        logic h_pol;
        logic v_pol;
    } timing_t;

    function automatic mode_t mk(
        input int hr, input int hf, input int hs, input int hb,
        input int vr, input int vf, input int vs, input int vb,
        input logic hp, input logic vp
    );
        mode_t m;
        m.h_res    = FW'(hr);
        m.h_fp     = FW'(hf);
        m.h_sync   = FW'(hs);
        m.h_bp     = FW'(hb);
        m.v_res    = FW'(vr);
        m.v_fp     = FW'(vf);
        m.v_sync   = FW'(vs);
        m.v_bp     = FW'(vb);
        m.h_pol    = hp;
        m.v_pol    = vp;
        m.h_tot    = FW'(hr + hf + hs + hb);
        m.v_tot    = FW'(vr + vf + vs + vb);
        m.h_last   = FW'(hr + hf + hs + hb - 1);
        m.v_last   = FW'(vr + vf + vs + vb - 1);
        m.hs_start = FW'(hr + hf);
        m.hs_end   = FW'(hr + hf + hs);
        m.vs_start = FW'(vr + vf);
        m.vs_end   = FW'(vr + vf + vs);
        return m;
    endfunction

    function automatic timing_t to_timing(input mode_t m);
        timing_t t;
        t.h_res    = m.h_res;
        t.v_res    = m.v_res;
        t.h_last   = m.h_last;
        t.v_last   = m.v_last;
        t.hs_start = m.hs_start;
        t.hs_end   = m.hs_end;
        t.vs_start = m.vs_start;
        t.vs_end   = m.vs_end;
        t.h_pol    = m.h_pol;
        t.v_pol    = m.v_pol;
        return t;
    endfunction

    // Listed from the highest index down: the first element lands in [8].
    localparam mode_t [NUM_STD_MODES-1:0] MODES = {
        mk(1600, 64, 192, 304, 1200, 1, 3, 46, 1'b1, 1'b1),
        mk(1280, 48, 112, 248, 1024, 1, 3, 38, 1'b1, 1'b1),
        mk(1280, 64, 136, 200, 800, 1, 3, 24, 1'b0, 1'b1),
        mk(1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0),
        mk(800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1),
        mk(768, 40, 80, 120, 576, 1, 3, 20, 1'b0, 1'b1),
        mk(768, 24, 80, 104, 576, 1, 3, 17, 1'b0, 1'b1),
        mk(800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1),
        mk(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0)
    };

endpackage

// File: rtl/display_mode_rom.sv
// Mode index to timing record lookup.
// Out-of-range indices return entry 0; the caller never applies them.
module display_mode_rom
    import display_modes_pkg::*;
#(
    parameter int NUM_MODES = NUM_STD_MODES,
    parameter int MODE_W = 4,
    parameter mode_t [NUM_MODES-1:0] TABLE = MODES
) (
    input  logic [MODE_W-1:0] idx,
    output timing_t           timing
);

    // Table select by index compare
    always_comb begin
        timing = to_timing(TABLE[0]);
        for (int i = 0; i < NUM_MODES; i++) begin
            if (idx == MODE_W'(i)) begin
                timing = to_timing(TABLE[i]);
            end
        end
    end

endmodule

// File: rtl/display_timing_multi.sv
// Runtime-selectable video timing generator with frame-aligned mode switch.
// Outputs are registered one cycle behind the raster counters.
module display_timing_multi
    import display_modes_pkg::*;
#(
    parameter int NUM_MODES = 9,
    parameter int MODE_W = 4,
    parameter int COORD_W = 13,
    parameter int DEFAULT_MODE = 5,
    parameter mode_t [NUM_MODES-1:0] MODE_TABLE = MODES
) (
    input  logic               i_pixel_clk,
    input  logic               i_reset_n,
    input  logic [MODE_W-1:0]  i_mode_sel,
    input  logic               i_mode_req,
    output logic               o_mode_ack,
    output logic               o_mode_err,
    output logic [MODE_W-1:0]  o_mode,
    output logic [2:0]         o_hve,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_line_start,
    output logic               o_frame_start
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] PENDING = 1'b1;

    localparam timing_t RST_T = to_timing(MODE_TABLE[DEFAULT_MODE]);
    localparam logic [MODE_W-1:0] RST_IDX = MODE_W'(DEFAULT_MODE);

    logic [0:0]         state;
    logic [MODE_W-1:0]  pend_idx;
    logic [MODE_W-1:0]  cur_idx;
    logic               pend_bad;
    logic               done;
    timing_t            cur;
    timing_t            next_t;
    logic [COORD_W-1:0] hc;
    logic [COORD_W-1:0] vc;
    fld_t               hx;
    fld_t               vx;
    logic               h_end;
    logic               v_end;
    logic               apply;
    logic               sel_ok;

    display_mode_rom #(
        .NUM_MODES (NUM_MODES),
        .MODE_W    (MODE_W),
        .TABLE     (MODE_TABLE)
    ) u_rom (
        .idx    (pend_idx),
        .timing (next_t)
    );

    assign hx     = FW'(hc);
    assign vx     = FW'(vc);
    assign h_end  = hx == cur.h_last;
    assign v_end  = vx == cur.v_last;
    assign sel_ok = 32'(i_mode_sel) < 32'(NUM_MODES);
    // done blocks a second apply on the first cycle of the new frame
    assign apply  = state == PENDING && !pend_bad && !done
                    && h_end && v_end;

    // Raster counters; a pending switch restarts them with the new mode
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hc      <= '0;
            vc      <= '0;
            cur     <= RST_T;
            cur_idx <= RST_IDX;
        end else if (apply) begin
            hc      <= '0;
            vc      <= '0;
            cur     <= next_t;
            cur_idx <= pend_idx;
        end else if (h_end) begin
            hc <= '0;
            vc <= v_end ? '0 : vc + 1'b1;
        end else begin
            hc <= hc + 1'b1;
        end
    end

    // Request handshake; PENDING is held until the ack cycle itself
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state    <= IDLE;
            pend_idx <= '0;
            pend_bad <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= apply;
            case (state)
                IDLE: begin
                    if (i_mode_req) begin
                        state    <= PENDING;
                        pend_idx <= i_mode_sel;
                        pend_bad <= !sel_ok;
                    end
                end
                PENDING: begin
                    if (pend_bad || done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered decode of sync, data enable, position and strobes
    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hve         <= {~RST_T.h_pol, ~RST_T.v_pol, 1'b0};
            o_x           <= '0;
            o_y           <= '0;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_mode        <= RST_IDX;
            o_mode_ack    <= 1'b0;
            o_mode_err    <= 1'b0;
        end else begin
            o_hve[2] <= (hx >= cur.hs_start && hx < cur.hs_end)
                        ~^ cur.h_pol;
            o_hve[1] <= (vx >= cur.vs_start && vx < cur.vs_end)
                        ~^ cur.v_pol;
            o_hve[0] <= hx < cur.h_res && vx < cur.v_res;
            o_x           <= hc;
            o_y           <= vc;
            o_line_start  <= hc == '0;
            o_frame_start <= hc == '0 && vc == '0;
            o_mode        <= cur_idx;
            o_mode_ack    <= done || (state == PENDING && pend_bad);
            o_mode_err    <= state == PENDING && pend_bad;
        end
    end

endmodule

// File: doc/display_timing_multi.md
# display_timing_multi

Runtime-selectable video timing generator: produces HDMI sync/data-enable (`hve`) and pixel coordinates for one of `NUM_MODES` stored video modes, driven from the divided pixel clock. It sits between the `CLKDIV` pixel clock and the `hdmi` encoder, feeding the pattern/pixel source with `x`/`y`. It supersedes the single-mode compile-time generator. Mode changes use a request/acknowledge handshake and always take effect on a frame boundary, so the sink never sees a truncated line or frame.

## Interface
Parameters:
- `NUM_MODES`, 9: number of entries in the mode table.
- `MODE_W`, 4: width of the mode index; must satisfy 2^MODE_W ≥ NUM_MODES.
- `COORD_W`, 13: width of the x/y counters. Every mode's H/V total must be ≤ 2^COORD_W.
- `DEFAULT_MODE`, 5: mode loaded at reset (1024x768@60).

Ports:
- `i_pixel_clk`, in, 1: pixel clock. All logic is on the rising edge.
- `i_reset_n`, in, 1: reset, asynchronous assert, active-low.
- `i_mode_sel`, in, MODE_W: requested mode index. Sampled when the request is accepted.
- `i_mode_req`, in, 1: mode-change request level. Hold high until `o_mode_ack`.
- `o_mode_ack`, out, 1: one-cycle pulse marking request completion.
- `o_mode_err`, out, 1: valid only with `o_mode_ack`. A value of 1 means the index was out of range and was rejected.
- `o_mode`, out, MODE_W: mode currently being generated.
- `o_hve`, out, 3: `{hsync, vsync, de}`. Sync levels are at the mode's polarity.
- `o_x`, `o_y`, out, COORD_W: raster position aligned with `o_hve`.
- `o_line_start`, out, 1: pulse with x==0 of every line.
- `o_frame_start`, out, 1: pulse with x==0, y==0.

## Operation
- Each mode-table entry holds:
  - H_RES, H_FP, H_SYNC, H_BP
  - V_RES, V_FP, V_SYNC, V_BP
  - H_POL, V_POL
- Totals are H_TOT = H_RES+H_FP+H_SYNC+H_BP, and likewise V_TOT.
- Counters `hc`/`vc`:
  - `hc` increments every cycle and wraps H_TOT-1 → 0.
  - `vc` increments when `hc` wraps, and wraps V_TOT-1 → 0.
- Decode:
  - de = (hc < H_RES) && (vc < V_RES).
  - hsync active for H_RES+H_FP ≤ hc < H_RES+H_FP+H_SYNC; vsync uses the analogous rule on `vc`.
  - Active sync level = POL (1 → high, 0 → low).
- Handshake FSM, states IDLE → PENDING → IDLE:
  - In IDLE, `i_mode_req`=1 captures `i_mode_sel` and moves to PENDING.
  - In PENDING, on the last cycle of a frame (hc==H_TOT-1 and vc==V_TOT-1), the captured index replaces the current mode. Counters restart at 0 using the new totals. `o_mode_ack` pulses on the output cycle carrying the new frame's x=0,y=0. The FSM returns to IDLE.
  - Out-of-range index (≥ NUM_MODES): ack one cycle after capture with `o_mode_err`=1. The mode is unchanged and there is no frame disturbance.
  - Same index as current: still waits for the frame boundary, then acks with err=0.
  - `i_mode_req` still high in IDLE after ack is treated as a new request. Requesters drop req on the ack cycle.
  - Changes on `i_mode_sel` during PENDING are ignored.
- Reset mid-frame or mid-request:
  - All state returns to reset values and PENDING is abandoned; no ack is issued.
  - Generation restarts in DEFAULT_MODE.

## Timing
- Reset values:
  - `o_x`=0, `o_y`=0, de=0.
  - hsync/vsync at the inactive level of DEFAULT_MODE.
  - `o_line_start`, `o_frame_start`, `o_mode_ack`, `o_mode_err` = 0.
  - `o_mode`=DEFAULT_MODE.
- Counters are 0 during reset. Outputs are registered and lag the counters by exactly 1 cycle, so the first cycle after reset release outputs x=0,y=0 with de=1 and `o_frame_start`=1.
- All outputs are mutually aligned with no skew between `o_hve`, `o_x`/`o_y` and the strobes.
- The mode switch is atomic: the last pixel of the old frame and the first pixel of the new frame are consecutive cycles.
- `o_mode` changes on the same cycle as the new frame's `o_frame_start`.
- Decode compares only against registered table fields; no adders sit in the per-pixel path. Totals and sync edges are precomputed in the package.

## Structure
- Package `display_modes_pkg`:
  - `mode_t` struct: resolutions, porches, syncs, polarities, plus derived H_TOT, V_TOT, HS_START, HS_END, VS_START, VS_END.
  - Constant `MODES[NUM_MODES]` in order: 640x480@60, 800x600@60, 768x576@73, 768x576@75, 800x600@72, 1024x768@60, 1280x800@60, 1280x1024@60, 1600x1200@57.
- Sub-module `display_mode_rom`: index → `mode_t` lookup. Its output is registered into the current-mode register when the new mode is applied.

## Test plan
- **Reset, default mode (1024x768@60):** release reset, then count one frame. Required: H_TOT=1344 cycles per line, V_TOT=806 lines, de asserted 1024×768 cycles, hsync low x 1048..1183, vsync low y 771..776.
- **Switch to mode 0 mid-frame:** req at y=100. Required: no change until the end of frame. Ack coincides with the next frame_start and `o_mode`=0. The new frame has 800×525 cycles, hsync low x 656..751, vsync low y 490..491.
- **Invalid index 12:** Required: ack with err=1 one cycle after capture, `o_mode` unchanged, raster period unbroken.
- **Polarity:** switch to mode 1 (800x600@60). Required: hsync high x 840..967, vsync high y 601..604.
- **Reset mid-PENDING:** assert `i_reset_n`=0 during PENDING. Required: no ack, outputs at reset values. After release, DEFAULT_MODE with frame_start on the first cycle.
- **Same-mode request:** request mode 5 while in mode 5. Required: ack with err=0 exactly at the frame boundary, and no glitch on `o_hve`.
